// File: rtl/if_id_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_id_stage_pkg
// Shared definitions for the IF/ID stage and its run-control FSM:
//   - run-state encodings (WAIT_LOAD, READY, RUN, HALT)
//   - default halt opcode and bubble word
//   - instruction field bit positions and a field-split helper
// ---------------------------------------------------------------------------
package if_id_stage_pkg;

  // Run-control states (legacy 2-bit encoding, visible on runState)
  localparam logic [1:0] ST_WAIT_LOAD = 2'd0;
  localparam logic [1:0] ST_READY     = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;
  localparam logic [1:0] ST_HALT      = 2'd3;

  localparam logic [5:0]  HALT_OPCODE_DEF = 6'h3F;
  localparam logic [31:0] NOP_WORD_DEF    = 32'h0000_0000;

  // Instruction field bit positions
  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int JIDX_MSB  = 25;
  localparam int JIDX_LSB  = 0;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm_se;
    logic [25:0] jidx;
  } id_fields_t;

  // Split an instruction word into its decode fields
  function automatic id_fields_t split_fields(input logic [31:0] instr);
    id_fields_t f;
    f.opcode = instr[OPC_MSB:OPC_LSB];
    f.rs     = instr[RS_MSB:RS_LSB];
    f.rt     = instr[RT_MSB:RT_LSB];
    f.rd     = instr[RD_MSB:RD_LSB];
    f.shamt  = instr[SHAMT_MSB:SHAMT_LSB];
    f.funct  = instr[FUNCT_MSB:FUNCT_LSB];
    f.imm_se = {{16{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};
    f.jidx   = instr[JIDX_MSB:JIDX_LSB];
    return f;
  endfunction

endpackage

// File: rtl/if_id_stage_run_control_fsm.sv
// ---------------------------------------------------------------------------
// run_control_fsm
// Run-control state machine gating instruction fetch.
// Ports:
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_program_loaded        instruction memory load complete
//   i_program_start         request to begin execution
//   i_halt_in_id            halt instruction currently valid in ID
//   i_stall, i_flush        hazard stall / branch flush
//   o_run_state             current state
//   o_run                   state == RUN
//   o_program_finished      state == HALT
//   o_pc_write_enable       PC may advance this cycle
// ---------------------------------------------------------------------------
module run_control_fsm
  import if_id_stage_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_program_loaded,
  input  logic       i_program_start,
  input  logic       i_halt_in_id,
  input  logic       i_stall,
  input  logic       i_flush,
  output logic [1:0] o_run_state,
  output logic       o_run,
  output logic       o_program_finished,
  output logic       o_pc_write_enable
);

  logic [1:0] r_state;
  logic       r_finished;
  logic [1:0] w_next_state;
  logic       w_halt_commit;

  // A halt in ID only takes effect when a flush is not squashing it
  assign w_halt_commit = i_halt_in_id && !i_flush;

  // Next-state selection
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_WAIT_LOAD: begin
        if (i_program_loaded) w_next_state = ST_READY;
        else                  w_next_state = ST_WAIT_LOAD;
      end
      ST_READY: begin
        if (i_program_start) w_next_state = ST_RUN;
        else                 w_next_state = ST_READY;
      end
      ST_RUN: begin
        if (w_halt_commit) w_next_state = ST_HALT;
        else               w_next_state = ST_RUN;
      end
      ST_HALT:  w_next_state = ST_HALT;
      default:  w_next_state = ST_WAIT_LOAD;
    endcase
  end

  // State register; finished flag registered alongside so it tracks HALT exactly
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_WAIT_LOAD;
      r_finished <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_finished <= (w_next_state == ST_HALT);
    end
  end

  assign o_run_state        = r_state;
  assign o_run              = (r_state == ST_RUN);
  assign o_program_finished = r_finished;
  assign o_pc_write_enable  = (r_state == ST_RUN) && !i_stall && !w_halt_commit;

endmodule

// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
// IF/ID pipeline register with run control, halt detection and field split.
// Ports:
//   clock, reset                      clock, synchronous active-high reset
//   programLoaded, programStart       run-control handshake
//   fullInstruction, incrPC           fetched word and its PC+4
//   stall, flush                      hazard hold / branch squash
//   pcWriteEnable                     PC may advance this cycle
//   ID_instruction, ID_incrPC, ID_valid   pipeline register contents
//   ID_opcode..ID_jumpTarget          decode fields of ID_instruction
//   runState, programFinished         run-control status
//   instrCount                        valid instructions captured
// ---------------------------------------------------------------------------
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEF,
  parameter logic [31:0] NOP_WORD    = NOP_WORD_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        programLoaded,
  input  logic        programStart,
  input  logic [31:0] fullInstruction,
  input  logic [31:0] incrPC,
  input  logic        stall,
  input  logic        flush,
  output logic        pcWriteEnable,
  output logic [31:0] ID_instruction,
  output logic [31:0] ID_incrPC,
  output logic        ID_valid,
  output logic [5:0]  ID_opcode,
  output logic [4:0]  ID_rs,
  output logic [4:0]  ID_rt,
  output logic [4:0]  ID_rd,
  output logic [4:0]  ID_shamt,
  output logic [5:0]  ID_funct,
  output logic [31:0] ID_immSE,
  output logic [31:0] ID_jumpTarget,
  output logic [1:0]  runState,
  output logic        programFinished,
  output logic [31:0] instrCount
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_incr_pc;
  logic [31:0] r_instr_count;

  logic        w_run;
  logic        w_halt_in_id;
  logic [31:0] w_id_instr;
  id_fields_t  w_fields;

  assign w_halt_in_id = r_valid && (r_instr[OPC_MSB:OPC_LSB] == HALT_OPCODE);

  run_control_fsm u_run_control_fsm (
    .i_clock            (clock),
    .i_reset            (reset),
    .i_program_loaded   (programLoaded),
    .i_program_start    (programStart),
    .i_halt_in_id       (w_halt_in_id),
    .i_stall            (stall),
    .i_flush            (flush),
    .o_run_state        (runState),
    .o_run              (w_run),
    .o_program_finished (programFinished),
    .o_pc_write_enable  (pcWriteEnable)
  );

  // IF/ID register: bubble outside RUN, flush beats stall, halt freezes the register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid       <= 1'b0;
      r_instr       <= NOP_WORD;
      r_incr_pc     <= 32'd0;
      r_instr_count <= 32'd0;
    end else if (!w_run) begin
      r_valid <= 1'b0;
      r_instr <= NOP_WORD;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_instr <= NOP_WORD;
    end else if (stall || w_halt_in_id) begin
      r_valid   <= r_valid;
      r_instr   <= r_instr;
      r_incr_pc <= r_incr_pc;
    end else begin
      r_valid       <= 1'b1;
      r_instr       <= fullInstruction;
      r_incr_pc     <= incrPC;
      r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign w_id_instr = r_valid ? r_instr : NOP_WORD;
  assign w_fields   = split_fields(w_id_instr);

  assign ID_instruction = w_id_instr;
  assign ID_incrPC      = r_incr_pc;
  assign ID_valid       = r_valid;
  assign ID_opcode      = w_fields.opcode;
  assign ID_rs          = w_fields.rs;
  assign ID_rt          = w_fields.rt;
  assign ID_rd          = w_fields.rd;
  assign ID_shamt       = w_fields.shamt;
  assign ID_funct       = w_fields.funct;
  assign ID_immSE       = w_fields.imm_se;
  assign ID_jumpTarget  = {r_incr_pc[31:28], w_fields.jidx, 2'b00};
  assign instrCount     = r_instr_count;

endmodule

// File: tb/tb_if_id_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage
// Scoreboard bench: a driver applies one cycle of stimulus at a time, asks a
// behavioural model what the outputs must look like during that cycle and
// queues it; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_if_id_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        programLoaded;
  logic        programStart;
  logic [31:0] fullInstruction;
  logic [31:0] incrPC;
  logic        stall;
  logic        flush;
  logic        pcWriteEnable;
  logic [31:0] ID_instruction;
  logic [31:0] ID_incrPC;
  logic        ID_valid;
  logic [5:0]  ID_opcode;
  logic [4:0]  ID_rs, ID_rt, ID_rd, ID_shamt;
  logic [5:0]  ID_funct;
  logic [31:0] ID_immSE;
  logic [31:0] ID_jumpTarget;
  logic [1:0]  runState;
  logic        programFinished;
  logic [31:0] instrCount;

  if_id_stage dut (
    .clock(clock), .reset(reset),
    .programLoaded(programLoaded), .programStart(programStart),
    .fullInstruction(fullInstruction), .incrPC(incrPC),
    .stall(stall), .flush(flush),
    .pcWriteEnable(pcWriteEnable),
    .ID_instruction(ID_instruction), .ID_incrPC(ID_incrPC), .ID_valid(ID_valid),
    .ID_opcode(ID_opcode), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd),
    .ID_shamt(ID_shamt), .ID_funct(ID_funct), .ID_immSE(ID_immSE),
    .ID_jumpTarget(ID_jumpTarget),
    .runState(runState), .programFinished(programFinished), .instrCount(instrCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        pcwe;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] incr;
    logic [1:0]  state;
    logic        fin;
    logic [31:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail_printed = 0;
  bit   driver_done = 1'b0;

  // Behavioural model: what the stage holds, in plain terms
  int          m_state;   // 0 wait-load, 1 ready, 2 run, 3 halted
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_incr;
  logic [31:0] m_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else if (n_fail_printed < 40) begin
      n_fail_printed++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // One clock cycle of stimulus: drive, predict outputs, advance the model
  task automatic cycle(input bit rst, input bit ld, input bit st,
                       input logic [31:0] fi, input logic [31:0] ipc,
                       input bit stl, input bit fl, input bit check);
    exp_t e;
    bit   halt_here;
    reset = rst; programLoaded = ld; programStart = st;
    fullInstruction = fi; incrPC = ipc; stall = stl; flush = fl;
    halt_here = m_valid && ((m_instr >> 26) == 32'd63);
    if (check) begin
      e.pcwe  = (m_state == 2) && !stl && !(halt_here && !fl);
      e.valid = m_valid;
      e.instr = m_valid ? m_instr : 32'd0;
      e.incr  = m_incr;
      e.state = m_state[1:0];
      e.fin   = (m_state == 3);
      e.count = m_count;
      exp_q.push_back(e);
    end
    @(posedge clock);
    if (rst) begin
      m_state = 0; m_valid = 0; m_instr = 32'd0; m_incr = 32'd0; m_count = 32'd0;
    end else begin
      // register update uses the state before this edge
      if (m_state != 2 || fl) begin
        m_valid = 0; m_instr = 32'd0;
      end else if (!(stl || halt_here)) begin
        m_valid = 1; m_instr = fi; m_incr = ipc; m_count = m_count + 32'd1;
      end
      case (m_state)
        0: if (ld) m_state = 1;
        1: if (st) m_state = 2;
        2: if (halt_here && !fl) m_state = 3;
        default: m_state = 3;
      endcase
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr(input bit want_halt);
    logic [31:0] w;
    w = $urandom;
    if (want_halt) w = w | 32'hFC00_0000;
    else if ((w >> 26) == 32'd63) w = w & 32'h7FFF_FFFF;
    return w;
  endfunction

  task automatic rand_run(input int n, input int halt_pct);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 1'b1, $urandom_range(1, 0) == 1, rand_instr($urandom_range(99, 0) < halt_pct),
            $urandom & 32'hFFFF_FFFC, $urandom_range(3, 0) == 0, $urandom_range(5, 0) == 0, 1'b1);
  endtask

  // Monitor: compare DUT outputs against the queued expectation mid-cycle
  initial begin
    exp_t e;
    logic [31:0] lo;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pcWriteEnable", {31'd0, pcWriteEnable}, {31'd0, e.pcwe});
        chk("ID_valid", {31'd0, ID_valid}, {31'd0, e.valid});
        chk("ID_instruction", ID_instruction, e.instr);
        chk("ID_incrPC", ID_incrPC, e.incr);
        chk("runState", {30'd0, runState}, {30'd0, e.state});
        chk("programFinished", {31'd0, programFinished}, {31'd0, e.fin});
        chk("instrCount", instrCount, e.count);
        chk("ID_opcode", {26'd0, ID_opcode}, e.instr >> 26);
        chk("ID_rs", {27'd0, ID_rs}, (e.instr >> 21) & 32'd31);
        chk("ID_rt", {27'd0, ID_rt}, (e.instr >> 16) & 32'd31);
        chk("ID_rd", {27'd0, ID_rd}, (e.instr >> 11) & 32'd31);
        chk("ID_shamt", {27'd0, ID_shamt}, (e.instr >> 6) & 32'd31);
        chk("ID_funct", {26'd0, ID_funct}, e.instr & 32'd63);
        lo = e.instr & 32'h0000_FFFF;
        chk("ID_immSE", ID_immSE, (lo >= 32'd32768) ? lo + 32'hFFFF_0000 : lo);
        chk("ID_jumpTarget", ID_jumpTarget,
            (e.incr & 32'hF000_0000) | ((e.instr & 32'h03FF_FFFF) * 32'd4));
      end
    end
  end

  initial begin
    // bring-up: reset in cycle 0, load at cycle 3, start pulse at cycle 6
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    // cycle 7: first RUN cycle, capture lw
    cycle(1'b0, 1'b1, 1'b0, 32'h8C22_FFFC, 32'h0000_0010, 1'b0, 1'b0, 1'b1);
    // stall two cycles, then stall+flush together
    cycle(1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h0000_0014, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h0000_0014, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h0000_0014, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'h0022_1820, 32'h0000_0018, 1'b0, 1'b0, 1'b1);
    // halt squashed by flush in the cycle it sits in ID
    cycle(1'b0, 1'b1, 1'b0, 32'hFC00_0000, 32'h0000_001C, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'h2001_0005, 32'h0000_0020, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'h0800_0040, 32'hA000_0024, 1'b0, 1'b0, 1'b1);
    rand_run(40, 0);
    // real halt, then fetches that must never be captured
    cycle(1'b0, 1'b1, 1'b0, 32'hFC00_0000, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 1'b1, 1'b1, rand_instr(1'b0), 32'h0000_0104, 1'b0, 1'b0, 1'b1);
    // restart, run, then reset mid-run with a valid instruction in ID
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b1, 1'b0, rand_instr(1'b0), $urandom, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, rand_instr(1'b0), 32'd4, 1'b0, 1'b0, 1'b1);
    // programStart without programLoaded stays in WAIT_LOAD
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b0, 1'b1, rand_instr(1'b0), 32'd8, 1'b0, 1'b0, 1'b1);
    // randomized runs with occasional halts and resets
    for (int r = 0; r < 4; r++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      rand_run(60, 4);
    end
    driver_done = 1'b1;
    // drain: expectation queue must empty within a bounded number of cycles
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
    @(posedge clock);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
